// File: rtl/cam_ctrl.sv
// 8-entry sequential-scan CAM controller: WRITE, SEARCH (one entry per cycle), CLEAR.
// Define CAM_CTRL_DUP_CHECK_EN to scan before each WRITE and reject duplicate keys.
module cam_ctrl #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [2:0]        cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   output logic [7:0]        rsp_status,
   output logic              rsp_hit,
   output logic [2:0]        rsp_hit_idx,
   output logic              rsp_dup,
   output logic [7:0]        valid_mask
);

   typedef enum logic [1:0] {IDLE, WRITE, SEARCH, DONE} state_t;
   typedef enum logic [1:0] {OP_NOP, OP_WRITE, OP_SEARCH, OP_CLEAR} op_t;

   state_t            state_q, state_d;
   op_t               op_q, op_d;
   logic [2:0]        addr_q, addr_d;
   logic [DATA_W-1:0] key_q, key_d;
   logic [2:0]        idx_q, idx_d;
   logic [7:0]        scan_q, scan_d;
   logic [DATA_W-1:0] mem_q [8];
   logic [DATA_W-1:0] mem_d [8];
   logic [7:0]        valid_q, valid_d;
   logic [7:0]        status_q, status_d;
   logic              hit_q, hit_d;
   logic [2:0]        hit_idx_q, hit_idx_d;
   logic [7:0]        cur_vec;
`ifdef CAM_CTRL_DUP_CHECK_EN
   logic              dup_q, dup_d;
`endif

   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      logic [2:0] r;
      r = '0;
      for (int unsigned i = 8; i > 0; i--) begin
         if (v[i-1]) r = 3'(i - 1);
      end
      return r;
   endfunction

   // Running match vector including the entry compared this cycle
   always_comb begin
      cur_vec         = scan_q;
      cur_vec[idx_q]  = valid_q[idx_q] && (mem_q[idx_q] == key_q);
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      key_d     = key_q;
      idx_d     = idx_q;
      scan_d    = scan_q;
      mem_d     = mem_q;
      valid_d   = valid_q;
      status_d  = status_q;
      hit_d     = hit_q;
      hit_idx_d = hit_idx_q;
`ifdef CAM_CTRL_DUP_CHECK_EN
      dup_d     = dup_q;
`endif
      case (state_q)
         IDLE: begin
            idx_d = '0;
            if (cmd_valid) begin
               op_d   = op_t'(cmd_op);
               addr_d = cmd_addr;
               key_d  = cmd_data;
               scan_d = '0;
               case (op_t'(cmd_op))
`ifdef CAM_CTRL_DUP_CHECK_EN
                  OP_WRITE:  state_d = SEARCH;
`else
                  OP_WRITE:  state_d = WRITE;
`endif
                  OP_SEARCH: state_d = SEARCH;
                  OP_CLEAR:  state_d = WRITE;
                  default:   state_d = IDLE;
               endcase
            end
         end
         SEARCH: begin
            scan_d = cur_vec;
            idx_d  = 3'(idx_q + 3'd1);
            if (idx_q == 3'd7) begin
               if (op_q == OP_SEARCH) begin
                  status_d  = cur_vec;
                  hit_d     = |cur_vec;
                  hit_idx_d = lowest_set(cur_vec);
`ifdef CAM_CTRL_DUP_CHECK_EN
                  dup_d     = 1'b0;
`endif
                  state_d   = DONE;
               end else begin
                  state_d   = WRITE;
               end
            end
         end
         WRITE: begin
            state_d = DONE;
            if (op_q == OP_CLEAR) begin
               valid_d = '0;
`ifdef CAM_CTRL_DUP_CHECK_EN
               dup_d   = 1'b0;
`endif
            end else begin
`ifdef CAM_CTRL_DUP_CHECK_EN
               dup_d = |scan_q;
               if (!(|scan_q)) begin
                  mem_d[addr_q]   = key_q;
                  valid_d[addr_q] = 1'b1;
               end
`else
               mem_d[addr_q]   = key_q;
               valid_d[addr_q] = 1'b1;
`endif
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         op_q      <= OP_NOP;
         addr_q    <= '0;
         key_q     <= '0;
         idx_q     <= '0;
         scan_q    <= '0;
         valid_q   <= '0;
         status_q  <= '0;
         hit_q     <= 1'b0;
         hit_idx_q <= '0;
         for (int unsigned i = 0; i < 8; i++) mem_q[i] <= '0;
`ifdef CAM_CTRL_DUP_CHECK_EN
         dup_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         key_q     <= key_d;
         idx_q     <= idx_d;
         scan_q    <= scan_d;
         valid_q   <= valid_d;
         status_q  <= status_d;
         hit_q     <= hit_d;
         hit_idx_q <= hit_idx_d;
         mem_q     <= mem_d;
`ifdef CAM_CTRL_DUP_CHECK_EN
         dup_q     <= dup_d;
`endif
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign rsp_valid   = (state_q == DONE);
   assign rsp_status  = status_q;
   assign rsp_hit     = hit_q;
   assign rsp_hit_idx = hit_idx_q;
   assign valid_mask  = valid_q;
`ifdef CAM_CTRL_DUP_CHECK_EN
   assign rsp_dup     = dup_q;
`else
   assign rsp_dup     = 1'b0;
`endif

endmodule
